// File: rtl/hdc_pkg.sv
// hdc_pkg: shared HDC encoder dimensions, bundler FSM states and hypervector type.
package hdc_pkg;
  localparam int HV_DIM = 256;
  localparam int FEATURES_PER_CC = 8;
  localparam int NUM_CHUNKS = 4;
  localparam int BUNDLE_CNT_W = 5;
  localparam int BUNDLE_THRESHOLD = 6;
  typedef logic [HV_DIM-1:0] hv_t;
  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} bundler_state_e;
endpackage

// File: rtl/enc_bit_accumulator.sv
// enc_bit_accumulator: saturating per-dimension vote counter with threshold compare.
module enc_bit_accumulator #(
  parameter int LANES = 4,
  parameter int CNT_W = 4,
  parameter int THRESHOLD = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             add_en,
  input  logic [LANES-1:0] column,
  output logic             hit
);
  localparam int AW = $clog2(LANES + 1);
  localparam int SW = (CNT_W > AW ? CNT_W : AW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc;
  logic [SW-1:0] sum;
  // sum is one bit wider than either operand so overflow is visible before clamping
  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) pc = pc + AW'(column[i]);
    sum = SW'(cnt_q) + SW'(pc);
    cnt_d = clear ? '0 : !add_en ? cnt_q : sum > CNT_MAX ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign hit = cnt_q >= CNT_W'(THRESHOLD);
endmodule

// File: rtl/enc_bundler.sv
// enc_bundler: accumulates NUM_CHUNKS beats of bound HVs and thresholds them into one bundled HV.
// Optional density output (popcount of bundled_hv) when ENC_BUNDLER_DENSITY_EN is defined.
module enc_bundler #(
  parameter int HV_DIM = hdc_pkg::HV_DIM,
  parameter int LANES = hdc_pkg::FEATURES_PER_CC / 2,
  parameter int NUM_CHUNKS = hdc_pkg::NUM_CHUNKS,
  parameter int CNT_W = hdc_pkg::BUNDLE_CNT_W,
  parameter int THRESHOLD = hdc_pkg::BUNDLE_THRESHOLD
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              in_valid,
  input  logic [HV_DIM-1:0] shifted_hv [0:LANES-1],
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] bundled_hv
`ifdef ENC_BUNDLER_DENSITY_EN
  ,
  output logic [$clog2(HV_DIM+1)-1:0] density
`endif
);
  import hdc_pkg::*;
  localparam int BW = $clog2(NUM_CHUNKS + 1);
  localparam int DW = $clog2(HV_DIM + 1);
  bundler_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic busy_q, busy_d, out_valid_q, out_valid_d;
  logic [HV_DIM-1:0] bundled_q, bundled_d, hits;
  logic [DW-1:0] density_q, density_d;
  logic clear, add_en, fire, last_beat;
  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [LANES-1:0] col;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign col[l] = shifted_hv[l][d];
    end
    enc_bit_accumulator #(.LANES(LANES), .CNT_W(CNT_W), .THRESHOLD(THRESHOLD)) u_acc (
      .clk(clk), .nrst(nrst), .clear(clear), .add_en(add_en), .column(col), .hit(hits[d])
    );
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      beat_q <= '0;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      bundled_q <= '0;
      density_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      bundled_q <= bundled_d;
      density_q <= density_d;
    end
  end
  assign last_beat = beat_q == BW'(NUM_CHUNKS - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = start_encoding ? ACCUM : IDLE;
      ACCUM:  state_d = start_encoding ? ACCUM : (in_valid && last_beat) ? THRESH : ACCUM;
      THRESH: state_d = start_encoding ? ACCUM : DONE;
      DONE:   state_d = !out_ready ? DONE : start_encoding ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // a start in DONE only takes effect together with the handshake, so a pending result is never lost
  always_comb begin
    clear = start_encoding && (state_q != DONE || out_ready);
    add_en = state_q == ACCUM && in_valid && !start_encoding;
    fire = state_q == THRESH && !start_encoding;
    beat_d = clear ? '0 : add_en ? beat_q + BW'(1) : beat_q;
    out_valid_d = fire ? 1'b1 : (state_q == DONE && out_ready) ? 1'b0 : out_valid_q;
    bundled_d = fire ? hits : bundled_q;
    busy_d = state_d == ACCUM || state_d == THRESH;
    density_d = '0;
    for (int i = 0; i < HV_DIM; i++) density_d = density_d + DW'(hits[i]);
    density_d = fire ? density_d : density_q;
  end
  assign busy = busy_q;
  assign out_valid = out_valid_q;
  assign bundled_hv = bundled_q;
`ifdef ENC_BUNDLER_DENSITY_EN
  assign density = density_q;
`else
  logic unused_density;
  assign unused_density = ^density_q;
`endif
endmodule

// File: tb/tb_enc_bundler.sv
// tb_enc_bundler: randomized bench for enc_bundler against a per-dimension vote-count model.
module tb_enc_bundler;
  localparam int W = 16, L = 4, N = 3, CW = 4, TH = 3;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, nrst = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] hv [0:L-1];
  logic busy, out_valid;
  logic [W-1:0] bundled;
  logic start5 = 0, in_valid5 = 0, out_ready5 = 1;
  logic [W-1:0] hv5 [0:L-1];
  logic busy5, out_valid5;
  logic [W-1:0] bundled5;
`ifdef ENC_BUNDLER_DENSITY_EN
  logic [4:0] density, density5;
`endif
  int vectors = 0, miscompares = 0;
  int raw [W];

  always #5 clk = ~clk;

  enc_bundler #(.HV_DIM(W), .LANES(L), .NUM_CHUNKS(N), .CNT_W(CW), .THRESHOLD(TH)) dut (
    .clk(clk), .nrst(nrst), .start_encoding(start), .in_valid(in_valid), .shifted_hv(hv),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .bundled_hv(bundled)
`ifdef ENC_BUNDLER_DENSITY_EN
    , .density(density)
`endif
  );

  enc_bundler #(.HV_DIM(W), .LANES(L), .NUM_CHUNKS(5), .CNT_W(CW), .THRESHOLD(TH)) dut5 (
    .clk(clk), .nrst(nrst), .start_encoding(start5), .in_valid(in_valid5), .shifted_hv(hv5),
    .busy(busy5), .out_valid(out_valid5), .out_ready(out_ready5), .bundled_hv(bundled5)
`ifdef ENC_BUNDLER_DENSITY_EN
    , .density(density5)
`endif
  );

  task automatic model_clear;
    for (int d = 0; d < W; d++) raw[d] = 0;
  endtask

  function automatic logic [W-1:0] model_hv();
    logic [W-1:0] r;
    for (int d = 0; d < W; d++) r[d] = ((raw[d] > SAT) ? SAT : raw[d]) >= TH;
    return r;
  endfunction

  function automatic logic [L*W-1:0] rand_beat();
    logic [L*W-1:0] v;
    for (int l = 0; l < L; l++) v[l*W +: W] = W'($urandom & $urandom);
    return v;
  endfunction

  task automatic start_pulse;
    start = 1;
    model_clear();
    @(negedge clk);
    start = 0;
  endtask

  task automatic beat(input logic [L*W-1:0] v);
    in_valid = 1;
    for (int l = 0; l < L; l++) begin
      hv[l] = v[l*W +: W];
      for (int d = 0; d < W; d++) raw[d] += int'(hv[l][d]);
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      for (int l = 0; l < L; l++) hv[l] = W'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic run_sample(input int max_gap, output logic [W-1:0] got, output bit ok);
    start_pulse();
    for (int b = 0; b < N; b++) begin
      idle_cycles($urandom_range(max_gap, 0));
      beat(rand_beat());
    end
    wait_valid(ok);
    got = bundled;
    handshake();
  endtask

  task automatic test_reset;
    vectors++;
    if ({busy, out_valid, bundled} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b out_valid=%b bundled=%h, want 0/0/0000", busy, out_valid, bundled);
    end
    vectors++;
    if ({busy5, out_valid5, bundled5} !== '0) begin
      miscompares++;
      $display("FAIL reset_state5: busy=%b out_valid=%b bundled=%h, want 0/0/0000", busy5, out_valid5, bundled5);
    end
  endtask

  task automatic test_basic;
    start_pulse();
    beat({16'h0001, 16'h0001, 16'h0001, 16'h0003});
    beat({16'h0001, 16'h0001, 16'h0001, 16'h0003});
    beat({16'h0001, 16'h0001, 16'h0001, 16'h0001});
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_thresh_cycle: out_valid=%b busy=%b, want 0/1", out_valid, busy);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid=%b busy=%b, want 1/0", out_valid, busy);
    end
    vectors++;
    if (bundled !== 16'h0001) begin
      miscompares++;
      $display("FAIL basic_value: got %h, want 0001", bundled);
    end
`ifdef ENC_BUNDLER_DENSITY_EN
    vectors++;
    if (density !== 5'd1) begin
      miscompares++;
      $display("FAIL basic_density: got %0d, want 1", density);
    end
`endif
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || bundled !== 16'h0001) begin
      miscompares++;
      $display("FAIL basic_after_hs: out_valid=%b bundled=%h, want 0/0001", out_valid, bundled);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] got, exp;
    bit ok;
    for (int s = 0; s < 20; s++) begin
      run_sample(s % 3, got, ok);
      exp = model_hv();
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("FAIL random_%0d: got %h (valid seen=%0d), want %h", s, got, ok, exp);
      end
`ifdef ENC_BUNDLER_DENSITY_EN
      vectors++;
      if (density !== 5'($countones(exp))) begin
        miscompares++;
        $display("FAIL random_density_%0d: got %0d, want %0d", s, density, $countones(exp));
      end
`endif
    end
  endtask

  task automatic test_saturation;
    logic [W-1:0] got;
    bit ok;
    start_pulse();
    repeat (N) beat({L*W{1'b1}});
    wait_valid(ok);
    got = bundled;
    handshake();
    vectors++;
    if (!ok || got !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_raw12: got %h, want ffff", got);
    end
    for (int run = 0; run < 2; run++) begin
      start5 = 1;
      @(negedge clk);
      start5 = 0;
      for (int b = 0; b < 5; b++) begin
        in_valid5 = 1;
        for (int l = 0; l < L; l++) hv5[l] = (run == 0 && b == 4) ? '0 : '1;
        @(negedge clk);
      end
      in_valid5 = 0;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        if (out_valid5) ok = 1;
        else @(negedge clk);
      end
      vectors++;
      if (!ok || bundled5 !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL sat_raw%0d: got %h, want ffff", run == 0 ? 16 : 20, bundled5);
      end
    end
  endtask

  task automatic test_stalls;
    logic [W-1:0] exp;
    bit ok;
    start_pulse();
    for (int b = 0; b < N; b++) begin
      idle_cycles(2);
      beat(rand_beat());
    end
    wait_valid(ok);
    exp = model_hv();
    vectors++;
    if (!ok || bundled !== exp) begin
      miscompares++;
      $display("FAIL stall_value: got %h, want %h", bundled, exp);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      for (int l = 0; l < L; l++) hv[l] = '1;
      start = (i == 2);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || bundled !== exp || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: out_valid=%b bundled=%h busy=%b, want 1/%h/0", i, out_valid, bundled, busy, exp);
      end
    end
    in_valid = 0;
    start = 0;
    handshake();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || bundled !== exp) begin
      miscompares++;
      $display("FAIL stall_release: out_valid=%b busy=%b bundled=%h, want 0/0/%h", out_valid, busy, bundled, exp);
    end
  endtask

  task automatic test_abort;
    bit ok;
    start_pulse();
    beat({L*W{1'b1}});
    beat(rand_beat());
    start = 1;
    in_valid = 1;
    for (int l = 0; l < L; l++) hv[l] = '1;
    model_clear();
    @(negedge clk);
    start = 0;
    in_valid = 0;
    repeat (N) beat('0);
    wait_valid(ok);
    vectors++;
    if (!ok || bundled !== 16'h0000) begin
      miscompares++;
      $display("FAIL abort_value: got %h, want 0000", bundled);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] got, exp;
    bit ok;
    start_pulse();
    repeat (N) beat({L*W{1'b1}});
    wait_valid(ok);
    handshake();
    start_pulse();
    beat(rand_beat());
    #2 nrst = 0;
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || bundled !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b out_valid=%b bundled=%h, want 0/0/0000", busy, out_valid, bundled);
    end
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    run_sample(1, got, ok);
    exp = model_hv();
    vectors++;
    if (!ok || got !== exp) begin
      miscompares++;
      $display("FAIL reset_recover: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp;
    bit ok;
    start_pulse();
    repeat (N) beat(rand_beat());
    wait_valid(ok);
    exp = model_hv();
    vectors++;
    if (!ok || bundled !== exp) begin
      miscompares++;
      $display("FAIL b2b_first: got %h, want %h", bundled, exp);
    end
    out_ready = 1;
    start = 1;
    model_clear();
    @(negedge clk);
    out_ready = 0;
    start = 0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_no_idle: out_valid=%b busy=%b, want 0/1", out_valid, busy);
    end
    repeat (N) beat(rand_beat());
    wait_valid(ok);
    exp = model_hv();
    vectors++;
    if (!ok || bundled !== exp) begin
      miscompares++;
      $display("FAIL b2b_second: got %h, want %h", bundled, exp);
    end
    handshake();
  endtask

  initial begin
    for (int l = 0; l < L; l++) begin
      hv[l] = '0;
      hv5[l] = '0;
    end
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    nrst = 1;
    @(negedge clk);
    test_basic();
    test_random();
    test_saturation();
    test_stalls();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
